// File: rtl/fp_drv_pkg.sv
// fp_drv_pkg
//   Shared definitions for the fp_op_driver command adapter:
//   - state_t  : driver FSM states
//   - QNAN     : canonical quiet NaN returned when the float unit times out
//   - SIGN_BIT : bit index of the IEEE-754 single-precision sign
package fp_drv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } state_t;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam int          SIGN_BIT = 31;

endpackage

// File: rtl/fp_drv_watchdog.sv
// fp_drv_watchdog
//   Cycle counter that bounds how long the driver waits for a result.
//   Only instantiated when FP_DRV_TIMEOUT_EN is defined.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   clear     : restart the count (asserted on the edge that enters WAIT_Z)
//   run       : high during every WAIT_Z cycle
//   expired   : high in the WAIT_Z cycle whose closing edge is the
//               TIMEOUT_CYCLES-th edge after WAIT_Z entry
module fp_drv_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of WAIT_Z edges already elapsed, so the limit is
  // reached on the edge where cnt already equals TIMEOUT_CYCLES-1.
  assign expired = run && (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (run && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fp_op_driver.sv
// fp_op_driver
//   Adapts a valid/ready command/response interface to a stb/ack
//   single-precision float unit (e.g. a multiplier). Sends operand A, then
//   operand B, waits for the result, optionally negates it and offers it as
//   the response.
// Configuration macro:
//   FP_DRV_TIMEOUT_EN : adds a WAIT_Z watchdog (TIMEOUT_CYCLES clk cycles);
//                       on expiry the response is the quiet NaN 0x7FC00000.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready               : command handshake
//   cmd_function_id[1:0]              : bit0 negates the result, bit1 ignored
//   cmd_inputs_0/cmd_inputs_1         : operands A and B
//   a_data/a_stb/a_ack                : operand A channel to the unit
//   b_data/b_stb/b_ack                : operand B channel to the unit
//   z_data/z_stb/z_ack                : result channel from the unit
//   rsp_valid/rsp_ready/rsp_outputs_0 : response handshake and result
//   busy                              : high whenever the FSM is not IDLE
module fp_op_driver
  import fp_drv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_function_id,
  input  logic [31:0] cmd_inputs_0,
  input  logic [31:0] cmd_inputs_1,
  output logic [31:0] a_data,
  output logic        a_stb,
  input  logic        a_ack,
  output logic [31:0] b_data,
  output logic        b_stb,
  input  logic        b_ack,
  input  logic [31:0] z_data,
  input  logic        z_stb,
  output logic        z_ack,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_outputs_0,
  output logic        busy
);

  state_t      state;
  logic [31:0] op_b;
  logic        negate;
  logic        timeout;
  logic        unused_func_bit;

  // Function bit 1 is reserved; it is deliberately not stored.
  assign unused_func_bit = cmd_function_id[1];

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fp_op_driver: TIMEOUT_CYCLES must be at least 1");
  end

  // Flip only the sign bit so NaN payloads and signed zeros stay intact.
  function automatic logic [31:0] apply_negate(input logic [31:0] z,
                                               input logic        neg);
    return {z[SIGN_BIT] ^ neg, z[SIGN_BIT-1:0]};
  endfunction

`ifdef FP_DRV_TIMEOUT_EN
  logic wd_clear;
  logic wd_run;

  assign wd_clear = (state == SEND_B) && b_stb && b_ack;
  assign wd_run   = (state == WAIT_Z);

  fp_drv_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .run     (wd_run),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      a_stb         <= 1'b0;
      b_stb         <= 1'b0;
      z_ack         <= 1'b0;
      rsp_valid     <= 1'b0;
      busy          <= 1'b0;
      a_data        <= '0;
      b_data        <= '0;
      op_b          <= '0;
      negate        <= 1'b0;
      rsp_outputs_0 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            a_data    <= cmd_inputs_0;
            op_b      <= cmd_inputs_1;
            negate    <= cmd_function_id[0];
            a_stb     <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SEND_A;
          end
        end

        SEND_A: begin
          if (a_stb && a_ack) begin
            a_stb  <= 1'b0;
            b_data <= op_b;
            b_stb  <= 1'b1;
            state  <= SEND_B;
          end
        end

        SEND_B: begin
          if (b_stb && b_ack) begin
            b_stb <= 1'b0;
            z_ack <= 1'b1;
            state <= WAIT_Z;
          end
        end

        WAIT_Z: begin
          if (z_stb && z_ack) begin
            rsp_outputs_0 <= apply_negate(z_data, negate);
            z_ack         <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else if (timeout) begin
            // A lost result is reported as a plain quiet NaN, never negated.
            rsp_outputs_0 <= QNAN;
            z_ack         <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          // cmd_ready is registered, so it is still low during the transfer
          // cycle and rises only after it.
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
          a_stb     <= 1'b0;
          b_stb     <= 1'b0;
          z_ack     <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
